rob_retire: RTL and testbench

Retire side of the reorder buffer: consumes up to two in-order head entries per cycle once they are marked commit-ready, and pops them from the ROB. Maintains the committed register alias table (CRAT, architectural → physical map) and returns each displaced physical register to the free list. Sits between the ROB head and the rename free list; the CRAT is readable for flush recovery.

---
 rtl/rob_retire.sv | 103 ++++++++++
 tb/tb_rob_retire.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// ROB retire stage: dual in-order commit, committed RAT, phys reg free.
// Optional retirement counter enabled by ROB_RETIRE_STATS_EN.
module rob_retire #(
  parameter int TAG_W     = 4,
  parameter int PHYS_W    = 8,
  parameter int ARCH_REGS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             head_valid,
  input  logic [1:0]             head_commit_ready,
  input  logic [1:0][TAG_W-1:0]  head_tag,
  input  logic [1:0][PHYS_W-1:0] head_phys_rd,
  input  logic [1:0][4:0]        head_arch_rd,
  output logic [1:0]             commit_en,
  output logic [1:0]             free_valid,
  output logic [1:0][PHYS_W-1:0] free_phys,
  input  logic                   free_ready,
  output logic [TAG_W-1:0]       last_tag,
  input  logic [4:0]             crat_raddr,
  output logic [PHYS_W-1:0]      crat_rdata
`ifdef ROB_RETIRE_STATS_EN
  ,
  output logic [63:0]            retired_count
`endif
);

  logic [PHYS_W-1:0] crat [ARCH_REGS];

  logic              out_free;
  logic [1:0]        wr;
  logic [PHYS_W-1:0] old0;
  logic [PHYS_W-1:0] old1;
  logic [1:0]        nxt_fv;
  logic [1:0][PHYS_W-1:0] nxt_fp;

  // Retire decision and displaced-register selection
  always_comb begin
    out_free     = !(|free_valid) || free_ready;
    commit_en    = 2'b00;
    commit_en[0] = head_valid[0] & head_commit_ready[0] & out_free;
    commit_en[1] = commit_en[0] & head_valid[1]
                 & head_commit_ready[1];
    wr[0] = commit_en[0] && (head_arch_rd[0] != 5'd0);
    wr[1] = commit_en[1] && (head_arch_rd[1] != 5'd0);
    old0  = crat[head_arch_rd[0]];
    old1  = crat[head_arch_rd[1]];
    if (wr[0] && head_arch_rd[0] == head_arch_rd[1])
      old1 = head_phys_rd[0];
    nxt_fv    = wr;
    nxt_fp[0] = wr[0] ? old0 : '0;
    nxt_fp[1] = wr[1] ? old1 : '0;
  end

  // Committed RAT; slot 1 written last so it wins on a shared arch_rd
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++)
        crat[i] <= PHYS_W'(i);
    end else begin
      if (wr[0])
        crat[head_arch_rd[0]] <= head_phys_rd[0];
      if (wr[1])
        crat[head_arch_rd[1]] <= head_phys_rd[1];
    end
  end

  // Free output register and youngest retired tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_valid <= '0;
      free_phys  <= '0;
      last_tag   <= '0;
    end else begin
      if (out_free) begin
        free_valid <= nxt_fv;
        free_phys  <= nxt_fp;
      end
      if (commit_en[1])
        last_tag <= head_tag[1];
      else if (commit_en[0])
        last_tag <= head_tag[0];
    end
  end

  // CRAT read reflects state at the last edge
  always_comb begin
    crat_rdata = crat[crat_raddr];
  end

`ifdef ROB_RETIRE_STATS_EN
  // Retired-entry counter, x0 retirements included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      retired_count <= '0;
    else
      retired_count <= retired_count
                     + 64'(commit_en[0])
                     + 64'(commit_en[1]);
  end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: in-order retire model plus directed literals.
// Build with ROB_RETIRE_STATS_EN to exercise the counter.
module tb_rob_retire;

  logic             clk;
  logic             rst;
  logic [1:0]       head_valid;
  logic [1:0]       head_commit_ready;
  logic [1:0][3:0]  head_tag;
  logic [1:0][7:0]  head_phys_rd;
  logic [1:0][4:0]  head_arch_rd;
  logic [1:0]       commit_en;
  logic [1:0]       free_valid;
  logic [1:0][7:0]  free_phys;
  logic             free_ready;
  logic [3:0]       last_tag;
  logic [4:0]       crat_raddr;
  logic [7:0]       crat_rdata;
`ifdef ROB_RETIRE_STATS_EN
  logic [63:0]      retired_count;
`endif

  int errors = 0;
  int checks = 0;

  rob_retire dut (
    .clk(clk),
    .rst(rst),
    .head_valid(head_valid),
    .head_commit_ready(head_commit_ready),
    .head_tag(head_tag),
    .head_phys_rd(head_phys_rd),
    .head_arch_rd(head_arch_rd),
    .commit_en(commit_en),
    .free_valid(free_valid),
    .free_phys(free_phys),
    .free_ready(free_ready),
    .last_tag(last_tag),
    .crat_raddr(crat_raddr),
    .crat_rdata(crat_rdata)
`ifdef ROB_RETIRE_STATS_EN
    ,
    .retired_count(retired_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // model state: architectural map, pending frees, tag, count
  logic [7:0]  m_crat [32];
  logic [1:0]  m_fv;
  logic [7:0]  m_fp [2];
  logic [3:0]  m_tag;
  logic [63:0] m_cnt;
  logic [7:0]  n_crat [32];
  logic [1:0]  n_fv;
  logic [7:0]  n_fp [2];
  logic [3:0]  n_tag;
  logic [63:0] n_cnt;
  logic        of_ok;
  int          n;

  // compare outputs against model, then compute the model's next state
  always @(negedge clk) begin
    chk("free_valid", 64'(free_valid), 64'(m_fv));
    chk("free_phys0", 64'(free_phys[0]), 64'(m_fp[0]));
    chk("free_phys1", 64'(free_phys[1]), 64'(m_fp[1]));
    chk("last_tag", 64'(last_tag), 64'(m_tag));
    chk("crat_rdata", 64'(crat_rdata), 64'(m_crat[crat_raddr]));
`ifdef ROB_RETIRE_STATS_EN
    chk("retired_count", retired_count, m_cnt);
`endif
    of_ok = (m_fv == 2'b00) || free_ready;
    n = 0;
    if (of_ok && head_valid[0] && head_commit_ready[0]) begin
      n = 1;
      if (head_valid[1] && head_commit_ready[1]) n = 2;
    end
    chk("commit_en", 64'(commit_en),
        (n == 2) ? 64'd3 : (n == 1) ? 64'd1 : 64'd0);
    for (int i = 0; i < 32; i++) n_crat[i] = m_crat[i];
    n_fv = m_fv;
    n_fp[0] = m_fp[0];
    n_fp[1] = m_fp[1];
    n_tag = m_tag;
    n_cnt = m_cnt + 64'(n);
    if (of_ok) begin
      n_fv = 2'b00;
      n_fp[0] = 8'd0;
      n_fp[1] = 8'd0;
    end
    // retire entries one at a time, oldest first
    for (int k = 0; k < n; k++) begin
      if (head_arch_rd[k] != 5'd0) begin
        n_fv[k] = 1'b1;
        n_fp[k] = n_crat[head_arch_rd[k]];
        n_crat[head_arch_rd[k]] = head_phys_rd[k];
      end
      n_tag = head_tag[k];
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_crat[i] <= 8'(i);
      m_fv <= 2'b00;
      m_fp[0] <= 8'd0;
      m_fp[1] <= 8'd0;
      m_tag <= 4'd0;
      m_cnt <= 64'd0;
    end else begin
      for (int i = 0; i < 32; i++) m_crat[i] <= n_crat[i];
      m_fv <= n_fv;
      m_fp[0] <= n_fp[0];
      m_fp[1] <= n_fp[1];
      m_tag <= n_tag;
      m_cnt <= n_cnt;
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] r,
                       input logic [3:0] t0, input logic [3:0] t1,
                       input logic [7:0] p0, input logic [7:0] p1,
                       input logic [4:0] a0, input logic [4:0] a1);
    head_valid = v;
    head_commit_ready = r;
    head_tag[0] = t0;
    head_tag[1] = t1;
    head_phys_rd[0] = p0;
    head_phys_rd[1] = p1;
    head_arch_rd[0] = a0;
    head_arch_rd[1] = a1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    free_ready = 1'b1;
    crat_raddr = 5'd0;
    idle();
    #12 rst = 1'b1;
    tick();

    // reset contents
    crat_raddr = 5'd0; #1 chk("lit_crat0", 64'(crat_rdata), 64'd0);
    crat_raddr = 5'd5; #1 chk("lit_crat5", 64'(crat_rdata), 64'd5);
    crat_raddr = 5'd31; #1 chk("lit_crat31", 64'(crat_rdata), 64'd31);
    chk("lit_rst_fv", 64'(free_valid), 64'd0);

    // slot 0 alone
    tick();
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'd40, 8'd0, 5'd5, 5'd0);
    #1 chk("lit_ce_01", 64'(commit_en), 64'd1);
    tick(); idle(); crat_raddr = 5'd5;
    #1 chk("lit_fv_01", 64'(free_valid), 64'd1);
    chk("lit_fp0_5", 64'(free_phys[0]), 64'd5);
    chk("lit_tag3", 64'(last_tag), 64'd3);
    chk("lit_crat5_40", 64'(crat_rdata), 64'd40);

    // both slots, same arch_rd
    tick();
    drive(2'b11, 2'b11, 4'd4, 4'd5, 8'd50, 8'd51, 5'd7, 5'd7);
    #1 chk("lit_ce_11", 64'(commit_en), 64'd3);
    tick(); idle(); crat_raddr = 5'd7;
    #1 chk("lit_fv_11", 64'(free_valid), 64'd3);
    chk("lit_fp0_7", 64'(free_phys[0]), 64'd7);
    chk("lit_fp1_50", 64'(free_phys[1]), 64'd50);
    chk("lit_crat7_51", 64'(crat_rdata), 64'd51);
    chk("lit_tag5", 64'(last_tag), 64'd5);

    // slot 0 not ready blocks slot 1
    tick();
    drive(2'b11, 2'b10, 4'd1, 4'd2, 8'd70, 8'd71, 5'd1, 5'd2);
    #1 chk("lit_ce_00", 64'(commit_en), 64'd0);
    tick();
    // x0 destination
    drive(2'b01, 2'b01, 4'd6, 4'd0, 8'd60, 8'd0, 5'd0, 5'd0);
    crat_raddr = 5'd0;
    #1 chk("lit_ce_x0", 64'(commit_en), 64'd1);
    tick(); idle();
    #1 chk("lit_fv_x0", 64'(free_valid), 64'd0);
    chk("lit_crat0_x0", 64'(crat_rdata), 64'd0);
    chk("lit_tag6", 64'(last_tag), 64'd6);

    // backpressure
    free_ready = 1'b0;
    drive(2'b01, 2'b01, 4'd7, 4'd0, 8'd33, 8'd0, 5'd3, 5'd0);
    tick();
    drive(2'b11, 2'b11, 4'd8, 4'd9, 8'd41, 8'd42, 5'd8, 5'd9);
    #1 chk("lit_bp_ce", 64'(commit_en), 64'd0);
    tick(); tick();
    chk("lit_bp_fv", 64'(free_valid), 64'd1);
    chk("lit_bp_fp", 64'(free_phys[0]), 64'd3);
    chk("lit_bp_ce2", 64'(commit_en), 64'd0);
    free_ready = 1'b1;
    #1 chk("lit_resume_ce", 64'(commit_en), 64'd3);
    tick(); idle();
    #1 chk("lit_resume_fv", 64'(free_valid), 64'd3);
    chk("lit_resume_fp0", 64'(free_phys[0]), 64'd8);
    chk("lit_resume_fp1", 64'(free_phys[1]), 64'd9);
    chk("lit_tag9", 64'(last_tag), 64'd9);

    // mixed stream, checked by the model every cycle
    for (int i = 0; i < 24; i++) begin
      tick();
      free_ready = (i % 3) != 0;
      drive(2'(i % 4), 2'((i * 3) % 4), 4'(i), 4'(i + 1),
            8'(64 + 2 * i), 8'(65 + 2 * i),
            5'(i % 5), 5'((i * 7) % 32));
      crat_raddr = 5'((i * 7) % 32);
    end
    tick();
    free_ready = 1'b1;
    drive(2'b11, 2'b11, 4'd2, 4'd3, 8'd90, 8'd91, 5'd7, 5'd12);
    tick();
    // async reset mid-cycle
    #2 rst = 1'b0;
    crat_raddr = 5'd7;
    #1 chk("lit_arst_fv", 64'(free_valid), 64'd0);
    chk("lit_arst_tag", 64'(last_tag), 64'd0);
    chk("lit_arst_crat", 64'(crat_rdata), 64'd7);
    idle();
    tick();
    rst = 1'b1;

    // ten dual retirements of x0
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, 2'b11, 4'(i), 4'(i), 8'd0, 8'd0, 5'd0, 5'd0);
      tick();
    end
    idle();
`ifdef ROB_RETIRE_STATS_EN
    #1 chk("lit_count20", retired_count, 64'd20);
`endif
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
